mem_access_unit: RTL
====================

# mem_access_unit

Load/store front end sitting directly upstream of the 64-bit big-endian RAM. It accepts one byte, half, word or dword request at a time from the CPU core over a valid/ready handshake. It performs the RAM transaction, using read-modify-write for sub-dword stores, and returns sign- or zero-extended load data over a second valid/ready handshake. It owns the RAM's `wr`/`addr` lines and drives the shared 64-bit data bus only while writing.

## Interface
Parameters:
- `ADDR_BITS`, default 34: implemented RAM address bits; only `req_addr[ADDR_BITS-1:0]` is used.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: request accepted on an edge where `req_valid && req_ready`.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `req_signed`  in  1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  64: byte address.
- `req_wdata`  in  64: store data, right-aligned (LSBs).
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: response consumed on an edge where `resp_valid && resp_ready`.
- `resp_rdata`  out  64: extended load data; 0 for stores and errors.
- `resp_err`  out  1: request rejected; no RAM write occurred.
- `ram_wr`  out  1: RAM write strobe.
- `ram_addr`  out  64: RAM address; `{'0, addr[ADDR_BITS-1:0]}`.
- `ram_data`  inout  64: shared RAM data bus; driven only when `ram_wr=1`, otherwise `'z`.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE: `req_ready=1`. On accept, latch `we`, `size`, `signed`, `addr`, `wdata`, then transition:
  - error → RESP with `err=1`;
  - load or sub-dword store → RD;
  - dword store → WR.
- Error: `addr[ADDR_BITS-1:0] > 2^ADDR_BITS-8`. The 8-byte window would exceed the array, so no RAM access is made. Alignment checking is described under Configuration.
- RD: `ram_wr=0`, `ram_addr`=latched address. Capture `ram_data` into the line register at the end of the cycle, then:
  - load → RESP;
  - store → WR.
- Big-endian layout: the byte at the request address is `line[63:56]`. An access of N bytes (N = 1, 2, 4, 8) uses `line[63:64-8N]`.
- Load result: `line[63:64-8N]` moved to the LSBs. Extended to 64 bits with copies of its MSB if `signed`, otherwise with zeros. For dword loads `signed` has no effect.
- WR: `ram_wr=1`, drives `ram_data` = merged line, then → RESP.
  - Merged line: `line[63:64-8N]` replaced by `wdata[8N-1:0]`; the remaining bytes keep their captured value.
  - Dword store: the merged line is `wdata`.
- RESP: `resp_valid=1`, and `resp_rdata`/`resp_err` are held stable. On `resp_ready` → IDLE.
- One request in flight; `req_ready=0` outside IDLE.

## Timing
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `ram_wr=0`, `ram_addr=0`, `ram_data` high-Z. Latched fields are cleared to 0.
- Reset asserted mid-operation returns the FSM to IDLE immediately. If reset arrives in WR, `ram_wr` falls asynchronously and no write commits. Any pending response is dropped.
- Latency from the accept edge E0 to `resp_valid` high:
  - load: 2 edges (E0→RD, E1→RESP);
  - sub-dword store: 3 edges (RD, WR, RESP);
  - dword store: 2 edges (WR, RESP);
  - error: 1 edge.
- The RAM write commits on the edge ending WR, which is the same edge that raises `resp_valid`.
- The response completes on edge Ek and IDLE is entered. The next request can be accepted no earlier than edge Ek+1, giving a peak throughput of 1 load per 3 cycles.
- `ram_addr` is stable throughout RD and WR. `ram_data` is driven only in WR, so there is no bus contention with the RAM read driver.
- `resp_valid` is held with stable data while `resp_ready=0`; the wait is unbounded.

## Configuration
- `MEM_ALIGN_CHECK_EN`:
  - Defined: a request with `addr[log2(N)-1:0] != 0` is an error. It goes IDLE→RESP with `resp_err=1`; no RAM read and no RAM write occur.
  - Undefined: misaligned accesses are legal and serviced normally. Only the out-of-range check raises `resp_err`.

## Test plan
- Dword store then load at 0x100 with data 0x0123456789ABCDEF → load returns 0x0123456789ABCDEF, `resp_err=0`. Latency is 2 edges for each, and RAM byte 0x100 holds 0x01.
- After the dword above, a byte store of 0xAA at 0x103, then a dword load at 0x100 → 0x012345AA89ABCDEF. Confirm the store takes RD+WR, with resp 3 edges after accept.
- Byte load at 0x108 with RAM byte 0x80:
  - `signed=1` → 0xFFFFFFFFFFFFFF80;
  - `signed=0` → 0x80.
- Half load at 0x101:
  - macro defined → `resp_err=1`, no RAM write, `ram_wr` never high;
  - macro undefined → returns 0x2345 (from the line written in the second scenario).
- Load at addr 2^34-7 → `resp_err=1`, resp 1 edge after accept.
- Hold `resp_ready=0` for 5 cycles: `resp_valid`/`resp_rdata` stay stable and `req_ready=0`. Separately, pull `rst_n` low during WR of a byte store: `ram_wr` drops at once, the target byte is unchanged, and all outputs return to their reset values.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front end for a 64-bit big-endian RAM: one request in flight, RMW for sub-dword
// stores, sign/zero-extended loads. Optional macro MEM_ALIGN_CHECK_EN rejects misaligned accesses.
module mem_access_unit #(
    parameter int unsigned ADDR_BITS = 34
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_wr,
    output logic [63:0] ram_addr,
    inout  wire  [63:0] ram_data
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    // Highest start address whose 8-byte window still fits in the array.
    localparam logic [ADDR_BITS-1:0] AddrLimit = {ADDR_BITS{1'b1}} - ADDR_BITS'(7);

    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic [1:0]             size_q, size_d;
    logic                   signed_q, signed_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [63:0]            wdata_q, wdata_d;
    logic [63:0]            line_q, line_d;
    logic [63:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [ADDR_BITS-1:0]   addr_in;
    logic                   req_err;
    logic                   align_err;
    logic [63:0]            merged;

    assign addr_in = req_addr[ADDR_BITS-1:0];

    generate
        if (ADDR_BITS < 64) begin : g_unused_addr
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[63:ADDR_BITS];
        end
    endgenerate

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        align_err = 1'b0;
        unique case (req_size)
            2'd0: align_err = 1'b0;
            2'd1: align_err = addr_in[0];
            2'd2: align_err = |addr_in[1:0];
            2'd3: align_err = |addr_in[2:0];
        endcase
    end
`else
    assign align_err = 1'b0;
`endif

    assign req_err = (addr_in > AddrLimit) || align_err;

    // The N accessed bytes live at the top of the line (big-endian).
    function automatic logic [63:0] load_ext(input logic [63:0] line, input logic [1:0] size,
                                             input logic sgn);
        logic [63:0] r;
        unique case (size)
            2'd0:    r = {{56{sgn & line[63]}}, line[63:56]};
            2'd1:    r = {{48{sgn & line[63]}}, line[63:48]};
            2'd2:    r = {{32{sgn & line[63]}}, line[63:32]};
            default: r = line;
        endcase
        return r;
    endfunction

    always_comb begin
        merged = line_q;
        unique case (size_q)
            2'd0:    merged[63:56] = wdata_q[7:0];
            2'd1:    merged[63:48] = wdata_q[15:0];
            2'd2:    merged[63:32] = wdata_q[31:0];
            default: merged        = wdata_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        signed_d   = signed_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        line_d     = line_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ram_wr     = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = addr_in;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_we && (req_size == 2'd3)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                line_d = ram_data;
                if (we_q) begin
                    state_d = StWr;
                end else begin
                    rdata_d = load_ext(ram_data, size_q, signed_q);
                    state_d = StResp;
                end
            end
            StWr: begin
                ram_wr  = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            line_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            line_q   <= line_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign ram_addr   = 64'(addr_q);
    // ram_wr decodes straight from state, so an async reset in WR drops it at once.
    assign ram_data   = ram_wr ? merged : 64'bz;

endmodule
